reg_readback_seq: RTL
=====================

Name: reg_readback_seq

Overview:
- Read-side counterpart of the register write-enable decoder.
- The decoder maps a 5-bit register index to per-register write enables for x0, x9 and x18..x27. This block does the reverse: it walks the same 12 registers, issues a read address for each, captures the read data and streams it out with a valid/ready handshake.
- Used for debug dump of the saved-register set and for end-of-test result checking.

Parameters:
- DATA_W, 32, width of register read data and output data.
- RD_LAT, 1, cycles from rd_addr presented to rd_data valid; legal range 0..3.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to begin a dump; sampled only in IDLE.
- reg_mask  input  12  per-slot enable; bit k selects slot k. Latched when start is accepted.
- rd_addr  output  5  register-file read address.
- rd_en  output  1  read request, high while a read is outstanding.
- rd_data  input  DATA_W  register-file read data.
- out_valid  output  1  stream beat valid.
- out_ready  input  1  downstream accept.
- out_data  output  DATA_W  captured register value.
- out_idx  output  5  register index of the current beat.
- out_last  output  1  marks the final enabled slot.
- busy  output  1  high from start acceptance until return to IDLE.
- done  output  1  one-cycle pulse on completion.

Behaviour:
- Slot-to-index map: slot 0 -> 0, slot 1 -> 9, slot k (k = 2..11) -> 16+k, giving indices 18..27. Slots are scanned in ascending order.
- Reset values: rd_addr = 0, rd_en = 0, out_valid = 0, out_data = 0, out_idx = 0, out_last = 0, busy = 0, done = 0. State is IDLE and the latched mask is 0.
- IDLE:
  - On start = 1, latch reg_mask and set busy = 1.
  - If the mask is nonzero, go to ISSUE at the first enabled slot.
  - If the mask is zero, go to FIN; no read and no beat occurs.
- ISSUE: drive rd_addr = slot index and rd_en = 1. If RD_LAT = 0, capture rd_data in this cycle and go to SEND. Otherwise go to WAIT and load the wait counter with RD_LAT.
- WAIT:
  - rd_addr and rd_en are held.
  - The counter decrements each cycle. Capture rd_data in the cycle the counter reaches 1, then go to SEND.
- Capture: out_data <= rd_data, out_idx <= slot index, out_last <= (no higher enabled slot).
- SEND:
  - out_valid = 1 and rd_en = 0.
  - out_data, out_idx and out_last are held stable while out_ready = 0.
  - On out_valid && out_ready: if out_last, go to FIN; otherwise go to ISSUE at the next enabled slot.
- FIN: done = 1 for exactly one cycle, busy = 0 and out_valid = 0, then go to IDLE.
- Latency:
  - First out_valid is asserted RD_LAT+2 cycles after the edge where start is sampled.
  - A handshake in cycle n gives the next out_valid in cycle n+2+RD_LAT.
- Boundary conditions:
  - start while busy is ignored.
  - reg_mask changes after acceptance have no effect.
  - out_ready high outside SEND has no effect.
  - Reset asserted mid-dump aborts immediately to IDLE with reset values; no done pulse is produced.
  - Single-bit mask gives exactly one beat with out_last = 1.
  - start in the same cycle as reset is ignored.
- Next-slot search is combinational priority logic over the remaining mask bits above the current slot.

Test Plan:
- RD_LAT = 1, mask = 12'hFFF, out_ready tied high, rd_data = 32'hA000_0000 + rd_addr:
  - 12 beats with out_idx 0, 9, 18..27 and out_data matching.
  - out_last only on idx 27.
  - First valid 3 cycles after start; one done pulse.
- mask = 12'b0000_0000_0110 (slots 1, 2):
  - Beats idx 9 then 18; out_last on 18.
  - done one cycle after the 18 handshake.
- mask = 0:
  - No out_valid and no rd_en.
  - busy high for 1 cycle, done pulses once, and the FSM returns to IDLE.
- Backpressure: out_ready low for 5 cycles on the idx 9 beat:
  - out_valid, out_data and out_idx stay stable.
  - Stream resumes with idx 18 (RD_LAT+2) cycles after acceptance.
- Reset asserted while in WAIT for idx 20:
  - Next cycle all outputs are at reset values, no done pulse.
  - A subsequent start restarts from slot 0.
- RD_LAT = 0 and RD_LAT = 3 builds with mask = 12'h801 (slots 0, 11):
  - Beats idx 0 and 27 with correct data.
  - rd_addr held through WAIT.
  - start pulses during the dump are ignored.

Source files
------------

// File: rtl/reg_readback_seq.sv
// Walks x0, x9, x18..x27 in slot order, reads each enabled one and streams it out with valid/ready.
// First beat lands RD_LAT+2 cycles after start; the held beat stays stable while out_ready_i is low.
module reg_readback_seq #(
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [11:0]       reg_mask_i,
    output logic [4:0]        rd_addr_o,
    output logic              rd_en_o,
    input  logic [DATA_W-1:0] rd_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [4:0]        out_idx_o,
    output logic              out_last_o,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, SEND, FIN} state_t;

    state_t              state_q;
    logic [11:0]         mask_q;
    logic [3:0]          slot_q;
    logic [1:0]          cnt_q;
    logic [4:0]          rd_addr_q;
    logic                rd_en_q;
    logic                out_valid_q;
    logic [DATA_W-1:0]   out_data_q;
    logic [4:0]          out_idx_q;
    logic                out_last_q;
    logic                busy_q;
    logic                done_q;

    // {found, slot}: first enabled slot at or above the search start.
    logic [4:0]          first_d;
    logic [4:0]          next_d;

    function automatic logic [4:0] slot_to_idx(input logic [3:0] slot);
        logic [4:0] idx;
        case (slot)
            4'd0:    idx = 5'd0;
            4'd1:    idx = 5'd9;
            default: idx = {1'b0, slot} + 5'd16;
        endcase
        return idx;
    endfunction

    function automatic logic [4:0] find_from(input logic [11:0] mask, input logic [4:0] from);
        logic [4:0] hit;
        hit = '0;
        for (int k = 11; k >= 0; k--) begin
            if (mask[k] && (5'(k) >= from)) begin
                hit = {1'b1, 4'(k)};
            end
        end
        return hit;
    endfunction

    assign first_d = find_from(reg_mask_i, 5'd0);
    assign next_d  = find_from(mask_q, {1'b0, slot_q} + 5'd1);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            mask_q      <= '0;
            slot_q      <= '0;
            cnt_q       <= '0;
            rd_addr_q   <= '0;
            rd_en_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        mask_q <= reg_mask_i;
                        busy_q <= 1'b1;
                        if (first_d[4]) begin
                            slot_q  <= first_d[3:0];
                            state_q <= ISSUE;
                        end else begin
                            state_q <= FIN;
                        end
                    end
                end
                ISSUE: begin
                    // The address leaves on this edge, so WAIT always adds one cycle on top of RD_LAT.
                    rd_addr_q <= slot_to_idx(slot_q);
                    rd_en_q   <= 1'b1;
                    cnt_q     <= 2'(RD_LAT);
                    state_q   <= WAIT;
                end
                WAIT: begin
                    if (cnt_q == 2'd0) begin
                        out_data_q  <= rd_data_i;
                        out_idx_q   <= slot_to_idx(slot_q);
                        out_last_q  <= ~next_d[4];
                        rd_en_q     <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= SEND;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                SEND: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        if (out_last_q) begin
                            state_q <= FIN;
                        end else begin
                            slot_q  <= next_d[3:0];
                            state_q <= ISSUE;
                        end
                    end
                end
                FIN: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rd_addr_o   = rd_addr_q;
    assign rd_en_o     = rd_en_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_idx_o   = out_idx_q;
    assign out_last_o  = out_last_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule
